// File: rtl/dvp_rgb565_capture.sv
// DVP 8-bit camera byte stream to RGB565 pixel stream with frame skip and geometry checking.
// Optional colour-bar generator enabled by defining DVP_TEST_PATTERN_EN.
module dvp_rgb565_capture #(
    parameter logic [11:0] H_DISP     = 12'd640,
    parameter logic [11:0] V_DISP     = 12'd480,
    parameter logic [3:0]  FRAME_SKIP = 4'd10,
    parameter logic        VSYNC_POL  = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cam_vsync,
    input  logic        cam_href,
    input  logic [7:0]  cam_data,
    input  logic        test_mode,
    output logic        RGB_hsync,
    output logic        RGB_vsync,
    output logic [15:0] RGB_data,
    output logic        RGB_de,
    output logic        frame_done,
    output logic        frame_err
);

    localparam int unsigned CNT_W   = 12;
    localparam int unsigned SKIP_W  = 4;
    localparam logic [CNT_W-1:0]  CNT_MAX  = 12'hFFF;
    localparam logic [SKIP_W-1:0] SKIP_MAX = 4'hF;

    typedef enum logic {ST_SKIP, ST_RUN} state_t;

    state_t             state_q, state_d;
    logic [SKIP_W-1:0]  skip_cnt_q, skip_cnt_d;
    logic               s1_vsync_q, s1_vsync_d;
    logic               s1_href_q, s1_href_d;
    logic [7:0]         s1_data_q, s1_data_d;
    logic               vs_prev_q, vs_prev_d;
    logic               hr_prev_q, hr_prev_d;
    logic               byte_sel_q, byte_sel_d;
    logic [7:0]         hi_q, hi_d;
    logic [CNT_W-1:0]   pix_cnt_q, pix_cnt_d;
    logic [CNT_W-1:0]   line_cnt_q, line_cnt_d;
    logic               fs_flag_q, fs_flag_d;
    logic               rgb_hsync_q, rgb_hsync_d;
    logic               rgb_vsync_q, rgb_vsync_d;
    logic [15:0]        rgb_data_q, rgb_data_d;
    logic               rgb_de_q, rgb_de_d;
    logic               frame_done_q, frame_done_d;
    logic               frame_err_q, frame_err_d;

    logic               frame_start_c;
    logic               href_fall_c;
    logic               pix_valid_c;
    logic [15:0]        pix_data_c;
    logic               run_c;

`ifdef DVP_TEST_PATTERN_EN
    localparam logic [CNT_W-1:0] BAR_W = (H_DISP < 12'd8) ? 12'd1 : (H_DISP >> 3);

    logic tp_q, tp_d;

    function automatic logic [15:0] bar_color(input logic [CNT_W-1:0] px);
        logic [CNT_W-1:0] bar;
        bar = px / BAR_W;
        case (bar)
            12'd0:   bar_color = 16'hFFFF;
            12'd1:   bar_color = 16'hFFE0;
            12'd2:   bar_color = 16'h07FF;
            12'd3:   bar_color = 16'h07E0;
            12'd4:   bar_color = 16'hF81F;
            12'd5:   bar_color = 16'hF800;
            12'd6:   bar_color = 16'h001F;
            default: bar_color = 16'h0000;
        endcase
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) tp_q <= 1'b0;
        else     tp_q <= tp_d;
    end

    // Pattern selection only changes on a frame boundary to avoid tearing.
    always_comb begin
        tp_d = tp_q;
        if (frame_start_c) tp_d = test_mode;
    end
`else
    logic unused_test_mode;
    assign unused_test_mode = test_mode;
`endif

    assign frame_start_c = s1_vsync_q & ~vs_prev_q;
    assign href_fall_c   = hr_prev_q & ~s1_href_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_SKIP;
            skip_cnt_q   <= '0;
            s1_vsync_q   <= 1'b0;
            s1_href_q    <= 1'b0;
            s1_data_q    <= '0;
            vs_prev_q    <= 1'b0;
            hr_prev_q    <= 1'b0;
            byte_sel_q   <= 1'b0;
            hi_q         <= '0;
            pix_cnt_q    <= '0;
            line_cnt_q   <= '0;
            fs_flag_q    <= 1'b0;
            rgb_hsync_q  <= 1'b0;
            rgb_vsync_q  <= 1'b0;
            rgb_data_q   <= '0;
            rgb_de_q     <= 1'b0;
            frame_done_q <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            skip_cnt_q   <= skip_cnt_d;
            s1_vsync_q   <= s1_vsync_d;
            s1_href_q    <= s1_href_d;
            s1_data_q    <= s1_data_d;
            vs_prev_q    <= vs_prev_d;
            hr_prev_q    <= hr_prev_d;
            byte_sel_q   <= byte_sel_d;
            hi_q         <= hi_d;
            pix_cnt_q    <= pix_cnt_d;
            line_cnt_q   <= line_cnt_d;
            fs_flag_q    <= fs_flag_d;
            rgb_hsync_q  <= rgb_hsync_d;
            rgb_vsync_q  <= rgb_vsync_d;
            rgb_data_q   <= rgb_data_d;
            rgb_de_q     <= rgb_de_d;
            frame_done_q <= frame_done_d;
            frame_err_q  <= frame_err_d;
        end
    end

    always_comb begin
        s1_vsync_d   = VSYNC_POL ? cam_vsync : ~cam_vsync;
        s1_href_d    = cam_href;
        s1_data_d    = cam_data;
        vs_prev_d    = s1_vsync_q;
        hr_prev_d    = s1_href_q;
        state_d      = state_q;
        skip_cnt_d   = skip_cnt_q;
        byte_sel_d   = 1'b0;
        hi_d         = hi_q;
        pix_cnt_d    = pix_cnt_q;
        line_cnt_d   = line_cnt_q;
        fs_flag_d    = frame_start_c;
        frame_err_d  = frame_err_q;
        frame_done_d = 1'b0;
        pix_valid_c  = 1'b0;
        pix_data_c   = {hi_q, s1_data_q};
`ifdef DVP_TEST_PATTERN_EN
        if (tp_q) pix_data_c = bar_color(pix_cnt_q);
`endif

        // A mismatch reported with frame_done lasts a single cycle.
        if (fs_flag_q) frame_err_d = 1'b0;

        if (s1_href_q) begin
            if (s1_vsync_q) begin
                frame_err_d = 1'b1;
            end else if (!byte_sel_q) begin
                hi_d       = s1_data_q;
                byte_sel_d = 1'b1;
            end else begin
                pix_valid_c = 1'b1;
                if (pix_cnt_q != CNT_MAX) pix_cnt_d = pix_cnt_q + 12'd1;
            end
        end

        if (href_fall_c && !s1_vsync_q) begin
            if ((pix_cnt_q != H_DISP) || byte_sel_q) frame_err_d = 1'b1;
            if (line_cnt_q != CNT_MAX) line_cnt_d = line_cnt_q + 12'd1;
            pix_cnt_d = '0;
        end

        if (frame_start_c) begin
            pix_cnt_d   = '0;
            line_cnt_d  = '0;
            byte_sel_d  = 1'b0;
            frame_err_d = 1'b0;
            if ((state_q == ST_RUN) && (line_cnt_q != '0)) begin
                frame_done_d = 1'b1;
                frame_err_d  = (line_cnt_q != V_DISP);
            end
            if (state_q == ST_SKIP) begin
                if (skip_cnt_q == FRAME_SKIP) state_d = ST_RUN;
                else if (skip_cnt_q != SKIP_MAX) skip_cnt_d = skip_cnt_q + 4'd1;
            end
        end

        // Gate on the next state so a newly enabled frame carries its own vsync.
        run_c       = (state_d == ST_RUN);
        rgb_de_d    = run_c & pix_valid_c;
        rgb_hsync_d = run_c & s1_href_q;
        rgb_vsync_d = run_c & s1_vsync_q;
        rgb_data_d  = run_c ? (pix_valid_c ? pix_data_c : rgb_data_q) : 16'h0000;
    end

    assign RGB_hsync  = rgb_hsync_q;
    assign RGB_vsync  = rgb_vsync_q;
    assign RGB_data   = rgb_data_q;
    assign RGB_de     = rgb_de_q;
    assign frame_done = frame_done_q;
    assign frame_err  = frame_err_q;

endmodule

// File: tb/tb_dvp_rgb565_capture.sv
// Randomized bench for dvp_rgb565_capture: frame-level reference model with pixel scoreboard.
module tb_dvp_rgb565_capture;

    localparam logic [11:0] H  = 12'd8;
    localparam logic [11:0] V  = 12'd4;
    localparam logic [3:0]  SK = 4'd2;
    localparam logic        VP = 1'b1;

    logic        clk = 1'b0;
    logic        rst;
    logic        cam_vsync, cam_href, test_mode;
    logic [7:0]  cam_data;
    logic        RGB_hsync, RGB_vsync, RGB_de, frame_done, frame_err;
    logic [15:0] RGB_data;

    dvp_rgb565_capture #(.H_DISP(H), .V_DISP(V), .FRAME_SKIP(SK), .VSYNC_POL(VP)) dut (
        .clk(clk), .rst(rst), .cam_vsync(cam_vsync), .cam_href(cam_href),
        .cam_data(cam_data), .test_mode(test_mode), .RGB_hsync(RGB_hsync),
        .RGB_vsync(RGB_vsync), .RGB_data(RGB_data), .RGB_de(RGB_de),
        .frame_done(frame_done), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [15:0] got_q[$];
    int          de_cyc_q[$];
    logic        done_err_q[$];

    always @(negedge clk) begin
        if (!rst) begin
            if (RGB_de) begin
                got_q.push_back(RGB_data);
                de_cyc_q.push_back(cyc);
            end
            if (frame_done) done_err_q.push_back(frame_err);
        end
    end

    int n_checks = 0;
    int n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model state
    int          frame_idx = 0;
    bit          cur_fwd = 1'b0, prev_fwd = 1'b0;
    int          cur_lines = 0;
    bit          cur_bad = 1'b0;
    bit          tp_act = 1'b0;
    int          drive_cyc = 0;
    logic [15:0] exp_q[$];

    function automatic logic [15:0] bar_exp(input int p);
        logic [15:0] colours [8];
        int idx;
        colours = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                    16'hF81F, 16'hF800, 16'h001F, 16'h0000};
        idx = (p * 8) / int'(H);
        if (idx > 7) idx = 7;
        return colours[idx];
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic vsync_edge;
        cam_href  = 1'b0;
        cam_vsync = VP;
        repeat (3) tick();
        cam_vsync = ~VP;
        repeat (3) tick();
        prev_fwd = cur_fwd;
        frame_idx++;
        cur_fwd = (frame_idx > int'(SK));
        check("done_count", 32'(done_err_q.size()), prev_fwd ? 32'd1 : 32'd0);
        if (prev_fwd && done_err_q.size() > 0)
            check("done_err", 32'(done_err_q[0]), 32'(cur_lines != int'(V)));
        check("err_cleared", 32'(frame_err), 32'd0);
        done_err_q.delete();
        got_q.delete();
        de_cyc_q.delete();
        exp_q.delete();
`ifdef DVP_TEST_PATTERN_EN
        tp_act = test_mode;
`endif
        cur_lines = 0;
        cur_bad   = 1'b0;
    endtask

    task automatic send_line(input int nbytes, input bit fixed);
        logic [7:0] fix_bytes [4];
        logic [7:0] b_val, hi;
        fix_bytes = '{8'hF8, 8'h00, 8'h07, 8'hE0};
        hi = 8'h00;
        for (int b = 0; b < nbytes; b++) begin
            b_val = (fixed && b < 4) ? fix_bytes[b] : 8'($urandom);
            cam_href = 1'b1;
            cam_data = b_val;
            if (fixed && b == 1) drive_cyc = cyc;
            if (b == 2) check("hsync", 32'(RGB_hsync), 32'(cur_fwd));
            if (b % 2 == 0) hi = b_val;
            else if (cur_fwd) exp_q.push_back(tp_act ? bar_exp(b / 2) : {hi, b_val});
            tick();
        end
        cam_href = 1'b0;
        cam_data = 8'($urandom);
        repeat ($urandom_range(2, 5)) tick();
        cur_lines++;
        if (nbytes != 2 * int'(H)) cur_bad = 1'b1;
    endtask

    task automatic end_frame;
        repeat (3) tick();
        check("de_count", 32'(got_q.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check("pixel", 32'(got_q[i]), 32'(exp_q[i]));
        check("frame_err", 32'(frame_err), 32'(cur_bad));
    endtask

    task automatic frame(input int nlines, input int bad_line, input int bad_bytes, input bit fixed);
        vsync_edge();
        for (int l = 0; l < nlines; l++)
            send_line((l == bad_line) ? bad_bytes : 2 * int'(H), fixed && (l == 0));
        end_frame();
    endtask

    task automatic check_idle(input string tag);
        check(tag, {13'd0, RGB_hsync, RGB_vsync, RGB_data, RGB_de, frame_done, frame_err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        cam_vsync = ~VP;
        cam_href = 1'b0;
        cam_data = 8'h00;
        test_mode = 1'b0;
        repeat (3) tick();
        check_idle("reset_state");
        rst = 1'b0;
        tick();

        frame(4, -1, 0, 1'b0);
        frame(4, -1, 0, 1'b0);
        frame(4, -1, 0, 1'b1);
        check("latency", (de_cyc_q.size() > 0) ? 32'(de_cyc_q[0] - drive_cyc) : 32'hFFFF_FFFF, 32'd2);
        frame(4, -1, 0, 1'b0);
        frame(4, 1, 15, 1'b0);
        frame(3, -1, 0, 1'b0);
        frame(4, 2, 20, 1'b0);
        frame(4, -1, 0, 1'b0);
`ifdef DVP_TEST_PATTERN_EN
        test_mode = 1'b1;
        frame(4, -1, 0, 1'b0);
        test_mode = 1'b0;
        frame(4, -1, 0, 1'b0);
`endif

        // Reset in the middle of a forwarded line that already carries an error
        vsync_edge();
        send_line(13, 1'b0);
        cam_href = 1'b1;
        for (int b = 0; b < 5; b++) begin
            cam_data = 8'($urandom);
            tick();
        end
        rst = 1'b1;
        #1;
        check_idle("reset_midline");
        tick();
        cam_href = 1'b0;
        rst = 1'b0;
        frame_idx = 0;
        cur_fwd = 1'b0;
        cur_lines = 0;
        cur_bad = 1'b0;
        tick();

        frame(4, -1, 0, 1'b0);
        frame(4, -1, 0, 1'b0);
        frame(4, -1, 0, 1'b0);
        frame(3, -1, 0, 1'b0);
        vsync_edge();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
